// File: rtl/register_file_param_sb.sv
// Parametrised dual-read / single-write register file with a per-register busy scoreboard.
// Latency: reads return registered data one cycle after a sampled READ, with VALID_R as the strobe.
// Backpressure: none; every request is accepted on every edge.
//
// Ports:
//   CLK, RST (async active-low)
//   READ, ADDR_R1, ADDR_R2 -> DATA_R1, DATA_R2, VALID_R   (registered read, 1 cycle)
//   WRITE, ADDR_W, DATA_W                                  (writeback; also clears busy)
//   LOCK, ADDR_L                                           (decode marks a pending producer)
//   BUSY_R1, BUSY_R2 (combinational), BUSY_CNT (registered popcount of busy bits)
//
// Optional feature macro: REGFILE_WRITE_BYPASS_EN
//   When defined, a read in the same cycle as a write to the same address returns the
//   write data, and BUSY_Rn drops for that address unless it is re-locked in that cycle.
module register_file_param_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  READ,
  input  logic [ADDR_WIDTH-1:0] ADDR_R1,
  input  logic [ADDR_WIDTH-1:0] ADDR_R2,
  output logic [DATA_WIDTH-1:0] DATA_R1,
  output logic [DATA_WIDTH-1:0] DATA_R2,
  output logic                  VALID_R,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDR_W,
  input  logic [DATA_WIDTH-1:0] DATA_W,
  input  logic                  LOCK,
  input  logic [ADDR_WIDTH-1:0] ADDR_L,
  output logic                  BUSY_R1,
  output logic                  BUSY_R2,
  output logic [ADDR_WIDTH:0]   BUSY_CNT
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_WIDTH-1:0] reg_q [DEPTH];
  logic [DEPTH-1:0]      busy_q, busy_d;
  logic [CW-1:0]         busy_cnt_q, busy_cnt_d;
  logic [DATA_WIDTH-1:0] data_r1_q, data_r2_q, rd1_d, rd2_d;
  logic                  valid_q;

  logic wr_en, lock_en, cnt_inc, cnt_dec;
  logic busy_r1, busy_r2;

  // Register 0 is inert when hardwired: no write, no lock, no clear.
  assign wr_en   = WRITE && !(ZR && (ADDR_W == '0));
  assign lock_en = LOCK  && !(ZR && (ADDR_L == '0));

  // Read data selection, including optional write-through forwarding.
  always_comb begin
    rd1_d = reg_q[ADDR_R1];
    rd2_d = reg_q[ADDR_R2];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (WRITE && (ADDR_W == ADDR_R1)) rd1_d = DATA_W;
    if (WRITE && (ADDR_W == ADDR_R2)) rd2_d = DATA_W;
`endif
    if (ZR && (ADDR_R1 == '0)) rd1_d = '0;
    if (ZR && (ADDR_R2 == '0)) rd2_d = '0;
  end

  // Scoreboard next state: clear first, then lock, so a same-address lock wins.
  // The count moves only on real 0->1 / 1->0 transitions; an increment and a
  // decrement can only coincide on different addresses, so they cancel.
  always_comb begin
    busy_d = busy_q;
    if (wr_en)   busy_d[ADDR_W] = 1'b0;
    if (lock_en) busy_d[ADDR_L] = 1'b1;
    cnt_inc = lock_en && !busy_q[ADDR_L];
    cnt_dec = wr_en && busy_q[ADDR_W] && !(lock_en && (ADDR_L == ADDR_W));
    busy_cnt_d = busy_cnt_q;
    if (cnt_inc && !cnt_dec)      busy_cnt_d = busy_cnt_q + CW'(1);
    else if (cnt_dec && !cnt_inc) busy_cnt_d = busy_cnt_q - CW'(1);
  end

  // Busy lookups reflect pre-edge state; bypass hides a hazard being resolved this cycle.
  always_comb begin
    busy_r1 = busy_q[ADDR_R1];
    busy_r2 = busy_q[ADDR_R2];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (WRITE && (ADDR_W == ADDR_R1) && !(LOCK && (ADDR_L == ADDR_R1))) busy_r1 = 1'b0;
    if (WRITE && (ADDR_W == ADDR_R2) && !(LOCK && (ADDR_L == ADDR_R2))) busy_r2 = 1'b0;
`endif
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) reg_q[i] <= '0;
    end else if (wr_en) begin
      reg_q[ADDR_W] <= DATA_W;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_r1_q  <= '0;
      data_r2_q  <= '0;
      valid_q    <= 1'b0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      valid_q    <= READ;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
      if (READ) begin
        data_r1_q <= rd1_d;
        data_r2_q <= rd2_d;
      end
    end
  end

  assign DATA_R1  = data_r1_q;
  assign DATA_R2  = data_r2_q;
  assign VALID_R  = valid_q;
  assign BUSY_R1  = busy_r1;
  assign BUSY_R2  = busy_r2;
  assign BUSY_CNT = busy_cnt_q;

endmodule

// File: tb/tb_register_file_param_sb.sv
// Directed bench for register_file_param_sb: one instance with register 0 hardwired
// (ZERO_REG=1) and one with an ordinary register 0 (ZERO_REG=0), driven in lockstep.
module tb_register_file_param_sb;

  logic        CLK = 1'b0;
  logic        RST;
  logic        READ, WRITE, LOCK;
  logic [4:0]  ADDR_R1, ADDR_R2, ADDR_W, ADDR_L;
  logic [31:0] DATA_W;

  logic [31:0] d1, d2, z_d1, z_d2;
  logic        vld, b1, b2, z_vld, z_b1, z_b2;
  logic [5:0]  cnt, z_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  register_file_param_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1)) dut (
    .CLK(CLK), .RST(RST), .READ(READ), .ADDR_R1(ADDR_R1), .ADDR_R2(ADDR_R2),
    .DATA_R1(d1), .DATA_R2(d2), .VALID_R(vld), .WRITE(WRITE), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .LOCK(LOCK), .ADDR_L(ADDR_L), .BUSY_R1(b1), .BUSY_R2(b2),
    .BUSY_CNT(cnt)
  );

  register_file_param_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0)) dut0 (
    .CLK(CLK), .RST(RST), .READ(READ), .ADDR_R1(ADDR_R1), .ADDR_R2(ADDR_R2),
    .DATA_R1(z_d1), .DATA_R2(z_d2), .VALID_R(z_vld), .WRITE(WRITE), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .LOCK(LOCK), .ADDR_L(ADDR_L), .BUSY_R1(z_b1), .BUSY_R2(z_b2),
    .BUSY_CNT(z_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    READ = 0; WRITE = 0; LOCK = 0;
    ADDR_W = 0; ADDR_L = 0; DATA_W = 0;
  endtask

  initial begin
    logic [31:0] exp_byp;
    logic        exp_bsy5;
`ifdef REGFILE_WRITE_BYPASS_EN
    exp_byp  = 32'hA5A5A5A5;
    exp_bsy5 = 1'b0;
`else
    exp_byp  = 32'h00000011;
    exp_bsy5 = 1'b1;
`endif
    idle();
    ADDR_R1 = 0; ADDR_R2 = 0;
    RST = 1'b1;
    #1 RST = 1'b0;
    #1;
    chk("rst_valid", vld, 0);
    chk("rst_cnt",   cnt, 0);
    chk("rst_data1", d1, 0);
    tick();
    tick();
    RST = 1'b1;

    // Read of never-written registers after reset.
    READ = 1; ADDR_R1 = 3; ADDR_R2 = 31;
    tick();
    chk("first_rd1",   d1, 0);
    chk("first_rd2",   d2, 0);
    chk("first_valid", vld, 1);
    chk("first_cnt",   cnt, 0);

    // Writes, including an attempted write to register 0.
    idle(); WRITE = 1; ADDR_W = 7; DATA_W = 32'hDEADBEEF;
    tick();
    chk("valid_drop", vld, 0);
    chk("hold_rd1",   d1, 0);
    ADDR_W = 0; DATA_W = 32'h1234;
    tick();
    idle(); READ = 1; ADDR_R1 = 7; ADDR_R2 = 0;
    tick();
    chk("rd_r7",       d1, 32'hDEADBEEF);
    chk("rd_r0_zero",  d2, 0);
    chk("rd_r0_plain", z_d2, 32'h1234);

    // Same-cycle read and write of one address.
    idle(); WRITE = 1; ADDR_W = 9; DATA_W = 32'h11;
    tick();
    READ = 1; ADDR_R1 = 9; ADDR_R2 = 7; DATA_W = 32'hA5A5A5A5;
    tick();
    chk("rw_same_rd1", d1, exp_byp);
    chk("rw_same_rd2", d2, 32'hDEADBEEF);
    idle(); READ = 1; ADDR_R1 = 9; ADDR_R2 = 9;
    tick();
    chk("rw_next_rd1", d1, 32'hA5A5A5A5);
    chk("rw_next_rd2", d2, 32'hA5A5A5A5);
    chk("b2b_valid",   vld, 1);

    // Scoreboard sequence.
    idle(); LOCK = 1; ADDR_L = 4;
    tick();
    ADDR_L = 5;
    tick();
    idle(); ADDR_R1 = 4; ADDR_R2 = 6;
    #1;
    chk("sb_cnt2",  cnt, 2);
    chk("sb_busy4", b1, 1);
    chk("sb_busy6", b2, 0);
    LOCK = 1; ADDR_L = 4; WRITE = 1; ADDR_W = 4; DATA_W = 32'h44;
    #1;
    chk("sb_lockwr_comb", b1, 1);
    tick();
    idle();
    #1;
    chk("sb_lockwr_busy", b1, 1);
    chk("sb_lockwr_cnt",  cnt, 2);
    WRITE = 1; ADDR_W = 5; DATA_W = 32'h55; ADDR_R2 = 5;
    #1;
    chk("sb_bypass_busy5", b2, exp_bsy5);
    tick();
    idle();
    #1;
    chk("sb_wr5_cnt",  cnt, 1);
    chk("sb_wr5_busy", b2, 0);
    LOCK = 1; ADDR_L = 4;
    tick();
    idle();
    #1;
    chk("sb_relock_cnt", cnt, 1);
    WRITE = 1; ADDR_W = 6; DATA_W = 32'h66;
    tick();
    idle();
    #1;
    chk("sb_wr_free_cnt", cnt, 1);

    // Lock every address.
    for (int i = 0; i < 32; i++) begin
      LOCK = 1; ADDR_L = 5'(i);
      tick();
    end
    idle(); ADDR_R1 = 0; ADDR_R2 = 31;
    #1;
    chk("all_cnt_zr",   cnt, 31);
    chk("all_cnt_pl",   z_cnt, 32);
    chk("all_b0_zr",    b1, 0);
    chk("all_b0_pl",    z_b1, 1);
    chk("all_b31",      b2, 1);

    // Asynchronous reset between edges.
    READ = 1; ADDR_R1 = 7; ADDR_R2 = 9;
    tick();
    chk("pre_rst_rd1", d1, 32'hDEADBEEF);
    #2 RST = 1'b0;
    #1;
    chk("mid_rst_rd1",   d1, 0);
    chk("mid_rst_rd2",   d2, 0);
    chk("mid_rst_valid", vld, 0);
    chk("mid_rst_cnt",   cnt, 0);
    chk("mid_rst_cnt0",  z_cnt, 0);
    chk("mid_rst_busy",  b1, 0);
    #2 RST = 1'b1;
    tick();
    chk("post_rst_rd1",   d1, 0);
    chk("post_rst_rd2",   d2, 0);
    chk("post_rst_valid", vld, 1);
    chk("post_rst_cnt",   cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
